// File: rtl/derm_inbuf_reader.sv
// Read sequencer for the 16-user DeRateMatching input buffer: walks a read window and streams words out.
// Optional DERM_INBUF_RD_MASK_EN zeroes lanes whose latched user-mask bit is clear.
module derm_inbuf_reader #(
  parameter int unsigned DATA_W    = 48,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned NUM_USERS = 16
) (
  input  logic                          i_core_clk,
  input  logic                          i_rx_rst,
  input  logic                          i_start,
  input  logic [ADDR_W-1:0]             i_base_addr,
  input  logic [ADDR_W:0]               i_word_count,
  input  logic [NUM_USERS-1:0]          i_user_mask,
  output logic [ADDR_W-1:0]             o_rd_addr,
  output logic                          o_rd_en,
  input  logic [DATA_W*NUM_USERS-1:0]   i_rd_data,
  output logic [DATA_W*NUM_USERS-1:0]   o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int unsigned WORD_W = DATA_W * NUM_USERS;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT               state;
  stateT               nextState;
  logic [ADDR_W-1:0]   rdAddr;
  logic [CNT_W-1:0]    wordCnt;
  logic [CNT_W-1:0]    issuedCnt;
  logic [NUM_USERS-1:0] userMask;
  logic                rdPend;
  logic                rdPendLast;
  logic                issue;
  logic                issueLast;
  logic                busyQ;
  logic                doneQ;

  logic [WORD_W-1:0]   fifoMem [2];
  logic [1:0]          fifoLast;
  logic                wrPtr;
  logic                rdPtr;
  logic [1:0]          fifoCnt;
  logic [1:0]          occAfterPop;
  logic                headValid;
  logic                push;
  logic                pop;
  logic                creditOk;
  logic [WORD_W-1:0]   captureWord;

  assign headValid   = (fifoCnt != 2'd0);
  assign push        = rdPend;
  assign pop         = headValid && i_ready;
  assign occAfterPop = fifoCnt - 2'(pop);
  // Credit counts this cycle's pop so the read stream keeps full rate under a held-high ready.
  assign creditOk    = (3'(occAfterPop) + 3'(rdPend)) < 3'd2;

  // Next-state and read-issue decode
  always_comb begin
    nextState = state;
    issue     = 1'b0;
    issueLast = 1'b0;
    case (state)
      IDLE: begin
        // A zero-length window passes through DRAIN, which finds nothing pending and completes.
        if (i_start) nextState = (i_word_count == CNT_W'(0)) ? DRAIN : RUN;
      end
      RUN: begin
        if (creditOk) begin
          issue = 1'b1;
          if (issuedCnt + CNT_W'(1) == wordCnt) begin
            issueLast = 1'b1;
            nextState = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (occAfterPop == 2'd0 && !rdPend) nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State, window parameters and read pipeline
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      state      <= IDLE;
      rdAddr     <= '0;
      wordCnt    <= '0;
      issuedCnt  <= '0;
      userMask   <= '0;
      rdPend     <= 1'b0;
      rdPendLast <= 1'b0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      state      <= nextState;
      rdPend     <= issue;
      rdPendLast <= issueLast;
      busyQ      <= (nextState != IDLE);
      doneQ      <= (nextState == DONE);
      if (state == IDLE && i_start) begin
        rdAddr    <= i_base_addr;
        wordCnt   <= i_word_count;
        userMask  <= i_user_mask;
        issuedCnt <= '0;
      end else if (issue) begin
        rdAddr    <= rdAddr + ADDR_W'(1);
        issuedCnt <= issuedCnt + CNT_W'(1);
      end
    end
  end

`ifdef DERM_INBUF_RD_MASK_EN
  // Inactive users are zeroed before they enter the FIFO
  always_comb begin
    captureWord = '0;
    for (int unsigned k = 0; k < NUM_USERS; k++) begin
      if (userMask[k]) captureWord[k*DATA_W +: DATA_W] = i_rd_data[k*DATA_W +: DATA_W];
    end
  end
`else
  logic unusedMask;
  assign captureWord = i_rd_data;
  assign unusedMask  = ^userMask;
`endif

  // Two-entry output FIFO absorbing the RAM read latency
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      for (int i = 0; i < 2; i++) fifoMem[i] <= '0;
      fifoLast <= '0;
      wrPtr    <= 1'b0;
      rdPtr    <= 1'b0;
      fifoCnt  <= 2'd0;
    end else begin
      if (push) begin
        fifoMem[wrPtr]  <= captureWord;
        fifoLast[wrPtr] <= rdPendLast;
        wrPtr           <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      fifoCnt <= fifoCnt + 2'(push) - 2'(pop);
    end
  end

  assign o_rd_addr = rdAddr;
  assign o_rd_en   = issue;
  assign o_data    = fifoMem[rdPtr];
  assign o_valid   = headValid;
  assign o_last    = headValid && fifoLast[rdPtr];
  assign o_busy    = busyQ;
  assign o_done    = doneQ;

endmodule

// File: tb/tb_derm_inbuf_reader.sv
// Directed self-checking bench for derm_inbuf_reader; cycle k of a window is k cycles after the start edge.
module tb_derm_inbuf_reader;

  localparam int unsigned DATA_W = 48;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned NUSR   = 16;
  localparam int unsigned WORD_W = DATA_W * NUSR;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W:0]   wordCount;
  logic [NUSR-1:0]   userMask;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdEn;
  logic [WORD_W-1:0] rdData = '0;
  logic [WORD_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;
  logic              busy;
  logic              done;
  logic              ramOnes = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] addrQ [$];
  logic [WORD_W-1:0] dataQ [$];
  logic              lastQ [$];
  int firstRdCyc, firstValidCyc, lastHsCyc, doneCyc, maxOut, stallBreaks, rdCount, validCount;
  logic busyCyc1, busyAfter, doneAfter;

  always #5 clk = ~clk;

  derm_inbuf_reader dut (
    .i_core_clk  (clk),
    .i_rx_rst    (rst),
    .i_start     (start),
    .i_base_addr (baseAddr),
    .i_word_count(wordCount),
    .i_user_mask (userMask),
    .o_rd_addr   (rdAddr),
    .o_rd_en     (rdEn),
    .i_rd_data   (rdData),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_last      (last),
    .o_busy      (busy),
    .o_done      (done)
  );

  function automatic logic [WORD_W-1:0] ramWord(input logic [ADDR_W-1:0] a);
    logic [WORD_W-1:0] w;
    for (int k = 0; k < 16; k++) w[k*48 +: 48] = {8'hA0, 8'(k), 21'd0, a};
    return w;
  endfunction

  // Buffer model: one-cycle read latency
  always @(posedge clk) begin
    if (rdEn) rdData <= ramOnes ? {WORD_W{1'b1}} : ramWord(rdAddr);
  end

  // Runs one window and records what the stream produced
  task automatic runWindow(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                           input logic [NUSR-1:0] m, input bit toggle);
    logic prevValid, prevReady;
    logic [WORD_W-1:0] prevData;
    int popped;
    bit seen;
    addrQ.delete(); dataQ.delete(); lastQ.delete();
    firstRdCyc = -1; firstValidCyc = -1; lastHsCyc = -1; doneCyc = -1;
    maxOut = 0; stallBreaks = 0; rdCount = 0; validCount = 0; popped = 0;
    prevValid = 1'b0; prevReady = 1'b1; prevData = '0; seen = 1'b0;
    busyCyc1 = 1'b0;
    @(negedge clk);
    start = 1'b1; baseAddr = b; wordCount = n; userMask = m; ready = 1'b1;
    for (int cyc = 1; cyc < 200 && !seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (cyc == 1) busyCyc1 = busy;
      if (rdEn) begin
        addrQ.push_back(rdAddr);
        rdCount++;
        if (firstRdCyc < 0) firstRdCyc = cyc;
      end
      if (prevValid && !prevReady && (!valid || data !== prevData)) stallBreaks++;
      if (valid) begin
        validCount++;
        if (firstValidCyc < 0) firstValidCyc = cyc;
      end
      if (valid && ready) begin
        dataQ.push_back(data);
        lastQ.push_back(last);
        popped++;
        if (last) lastHsCyc = cyc;
      end
      if (rdCount - popped > maxOut) maxOut = rdCount - popped;
      if (done) begin
        seen = 1'b1;
        doneCyc = cyc;
      end
      prevValid = valid; prevReady = ready; prevData = data;
    end
    @(negedge clk);
    #1;
    busyAfter = busy;
    doneAfter = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0; baseAddr = '0; wordCount = '0; userMask = '0;
    repeat (2) @(negedge clk);
    checks++; if (rdAddr !== 11'd0) begin errors++; $display("FAIL reset_rd_addr got %0h want 0", rdAddr); end
    checks++; if (rdEn !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b want 0", rdEn); end
    checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [ADDR_W-1:0] ea;
    runWindow(11'h010, 12'd4, 16'hFFFF, 1'b0);
    checks++; if (busyCyc1 !== 1'b1) begin errors++; $display("FAIL basic_busy_t1 got %0b want 1", busyCyc1); end
    checks++; if (firstRdCyc !== 1) begin errors++; $display("FAIL basic_first_rd got %0d want 1", firstRdCyc); end
    checks++; if (addrQ.size() !== 4) begin errors++; $display("FAIL basic_rd_count got %0d want 4", addrQ.size()); end
    for (int i = 0; i < addrQ.size(); i++) begin
      ea = 11'(11'h010 + i);
      checks++; if (addrQ[i] !== ea) begin errors++; $display("FAIL basic_addr%0d got %0h want %0h", i, addrQ[i], ea); end
    end
    checks++; if (firstValidCyc !== 3) begin errors++; $display("FAIL basic_first_valid got %0d want 3", firstValidCyc); end
    checks++; if (dataQ.size() !== 4) begin errors++; $display("FAIL basic_words got %0d want 4", dataQ.size()); end
    for (int i = 0; i < dataQ.size(); i++) begin
      ea = 11'(11'h010 + i);
      checks++; if (dataQ[i] !== ramWord(ea)) begin errors++; $display("FAIL basic_data%0d got %0h want %0h", i, dataQ[i], ramWord(ea)); end
      checks++; if (lastQ[i] !== (i == 3)) begin errors++; $display("FAIL basic_last%0d got %0b want %0b", i, lastQ[i], i == 3); end
    end
    checks++; if (lastHsCyc !== 6) begin errors++; $display("FAIL basic_last_cycle got %0d want 6", lastHsCyc); end
    checks++; if (doneCyc !== 7) begin errors++; $display("FAIL basic_done_cycle got %0d want 7", doneCyc); end
    checks++; if (busyAfter !== 1'b0 || doneAfter !== 1'b0) begin errors++; $display("FAIL basic_busy_done_fall got busy=%0b done=%0b want 0 0", busyAfter, doneAfter); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] ea;
    runWindow(11'h7FE, 12'd4, 16'hFFFF, 1'b0);
    checks++; if (addrQ.size() !== 4) begin errors++; $display("FAIL wrap_rd_count got %0d want 4", addrQ.size()); end
    for (int i = 0; i < addrQ.size(); i++) begin
      ea = 11'(11'h7FE + i);
      checks++; if (addrQ[i] !== ea) begin errors++; $display("FAIL wrap_addr%0d got %0h want %0h", i, addrQ[i], ea); end
    end
    checks++; if (dataQ.size() !== 4) begin errors++; $display("FAIL wrap_words got %0d want 4", dataQ.size()); end
    for (int i = 0; i < dataQ.size(); i++) begin
      ea = 11'(11'h7FE + i);
      checks++; if (dataQ[i] !== ramWord(ea)) begin errors++; $display("FAIL wrap_data%0d got %0h want %0h", i, dataQ[i], ramWord(ea)); end
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] ea;
    runWindow(11'h200, 12'd8, 16'hFFFF, 1'b1);
    checks++; if (dataQ.size() !== 8) begin errors++; $display("FAIL bp_words got %0d want 8", dataQ.size()); end
    for (int i = 0; i < dataQ.size(); i++) begin
      ea = 11'(11'h200 + i);
      checks++; if (dataQ[i] !== ramWord(ea)) begin errors++; $display("FAIL bp_data%0d got %0h want %0h", i, dataQ[i], ramWord(ea)); end
      checks++; if (lastQ[i] !== (i == 7)) begin errors++; $display("FAIL bp_last%0d got %0b want %0b", i, lastQ[i], i == 7); end
    end
    checks++; if (rdCount !== 8) begin errors++; $display("FAIL bp_reads got %0d want 8", rdCount); end
    checks++; if (stallBreaks !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d want 0", stallBreaks); end
    checks++; if (maxOut > 2) begin errors++; $display("FAIL bp_outstanding got %0d want <=2", maxOut); end
    checks++; if (lastHsCyc < 0 || doneCyc !== lastHsCyc + 1) begin errors++; $display("FAIL bp_done_cycle got %0d want %0d", doneCyc, lastHsCyc + 1); end
  endtask

  task automatic test_zero_count();
    runWindow(11'h055, 12'd0, 16'hFFFF, 1'b0);
    checks++; if (busyCyc1 !== 1'b1) begin errors++; $display("FAIL zero_busy_t1 got %0b want 1", busyCyc1); end
    checks++; if (doneCyc !== 2) begin errors++; $display("FAIL zero_done_cycle got %0d want 2", doneCyc); end
    checks++; if (rdCount !== 0) begin errors++; $display("FAIL zero_reads got %0d want 0", rdCount); end
    checks++; if (validCount !== 0) begin errors++; $display("FAIL zero_valid got %0d want 0", validCount); end
    checks++; if (busyAfter !== 1'b0) begin errors++; $display("FAIL zero_busy_fall got %0b want 0", busyAfter); end
  endtask

  task automatic test_mask();
    logic [WORD_W-1:0] exp;
`ifdef DERM_INBUF_RD_MASK_EN
    exp = '0;
    exp[47:0] = {48{1'b1}};
`else
    exp = {WORD_W{1'b1}};
`endif
    ramOnes = 1'b1;
    runWindow(11'h020, 12'd1, 16'h0001, 1'b0);
    ramOnes = 1'b0;
    checks++; if (dataQ.size() !== 1) begin errors++; $display("FAIL mask_words got %0d want 1", dataQ.size()); end
    if (dataQ.size() > 0) begin
      checks++; if (dataQ[0] !== exp) begin errors++; $display("FAIL mask_data got %0h want %0h", dataQ[0], exp); end
    end
  endtask

  task automatic test_abort();
    int pops = 0;
    @(negedge clk);
    start = 1'b1; baseAddr = 11'h100; wordCount = 12'd10; userMask = 16'hFFFF; ready = 1'b1;
    for (int cyc = 1; cyc < 40 && pops < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (valid && ready) pops++;
    end
    checks++; if (pops !== 3) begin errors++; $display("FAIL abort_pops got %0d want 3", pops); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({rdAddr, rdEn, valid, last, busy, done} !== '0) begin errors++; $display("FAIL abort_ctrl got addr=%0h en=%0b v=%0b l=%0b b=%0b d=%0b want all 0", rdAddr, rdEn, valid, last, busy, done); end
    checks++; if (data !== '0) begin errors++; $display("FAIL abort_data got %0h want 0", data); end
    @(negedge clk);
    rst = 1'b0;
    runWindow(11'h000, 12'd2, 16'hFFFF, 1'b0);
    checks++; if (dataQ.size() !== 2) begin errors++; $display("FAIL abort_rerun_words got %0d want 2", dataQ.size()); end
    for (int i = 0; i < dataQ.size(); i++) begin
      checks++; if (dataQ[i] !== ramWord(11'(i))) begin errors++; $display("FAIL abort_rerun_data%0d got %0h want %0h", i, dataQ[i], ramWord(11'(i))); end
      checks++; if (lastQ[i] !== (i == 1)) begin errors++; $display("FAIL abort_rerun_last%0d got %0b want %0b", i, lastQ[i], i == 1); end
    end
    checks++; if (doneCyc !== 5) begin errors++; $display("FAIL abort_rerun_done got %0d want 5", doneCyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_mask();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
